// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between instruction fetch (I) and load/store (D).
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int unsigned ADDRW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [ADDRW-1:0] i_addr,
    output logic             i_rsp_valid,
    output logic [31:0]      i_rsp_rdata,
    output logic             i_rsp_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [2:0]       d_funct3,
    input  logic [ADDRW-1:0] d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_rsp_valid,
    output logic [31:0]      d_rsp_rdata,
    output logic             d_rsp_err,
    output logic             mem_we,
    output logic [2:0]       mem_funct3,
    output logic [ADDRW-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             busy
);

    localparam int unsigned DATAW = 32;
    localparam logic        PORT_I = 1'b0;
    localparam logic        PORT_D = 1'b1;
    localparam logic [2:0]  FETCH_FUNCT3 = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic               mem_we_q, mem_we_d;
    logic [2:0]         mem_funct3_q, mem_funct3_d;
    logic [ADDRW-1:0]   mem_addr_q, mem_addr_d;
    logic [DATAW-1:0]   mem_wdata_q, mem_wdata_d;
    logic               i_rsp_valid_q, i_rsp_valid_d;
    logic               d_rsp_valid_q, d_rsp_valid_d;
    logic               i_rsp_err_q, i_rsp_err_d;
    logic               d_rsp_err_q, d_rsp_err_d;

    logic               grant_any_c;
    logic               grant_sel_c;
    logic [ADDRW-1:0]   sel_addr_c;
    logic [2:0]         sel_funct3_c;
    logic               sel_we_c;
    logic [DATAW-1:0]   sel_wdata_c;
    logic               sel_legal_c;
    logic               rsp_rd_c;

    // Winner selection among simultaneous requesters.
    always_comb begin
        grant_any_c = i_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_sel_c = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
        end else begin
            grant_sel_c = d_req ? PORT_D : PORT_I;
        end
`else
        grant_sel_c = d_req ? PORT_D : PORT_I;
`endif
    end

    // Request fields of the winner and their alignment check.
    always_comb begin
        sel_addr_c   = (grant_sel_c == PORT_D) ? d_addr : i_addr;
        sel_funct3_c = (grant_sel_c == PORT_D) ? d_funct3 : FETCH_FUNCT3;
        sel_we_c     = (grant_sel_c == PORT_D) & d_we;
        sel_wdata_c  = (grant_sel_c == PORT_D) ? d_wdata : '0;
        case (sel_funct3_c[1:0])
            2'b00:   sel_legal_c = 1'b1;
            2'b01:   sel_legal_c = ~sel_addr_c[0];
            2'b10:   sel_legal_c = (sel_addr_c[1:0] == 2'b00);
            default: sel_legal_c = 1'b0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        we_d          = we_q;
        err_d         = err_q;
        mem_we_d      = 1'b0;
        mem_funct3_d  = mem_funct3_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        i_rsp_valid_d = 1'b0;
        d_rsp_valid_d = 1'b0;
        i_rsp_err_d   = 1'b0;
        d_rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_any_c) begin
                    owner_d      = grant_sel_c;
                    last_grant_d = grant_sel_c;
                    we_d         = sel_we_c;
                    err_d        = ~sel_legal_c;
                    if (sel_legal_c) begin
                        state_d      = ST_ISSUE;
                        mem_we_d     = sel_we_c;
                        mem_funct3_d = sel_funct3_c;
                        mem_addr_d   = sel_addr_c;
                        mem_wdata_d  = sel_wdata_c;
                    end else begin
                        // Rejected access skips the memory cycle entirely.
                        state_d       = ST_RESP;
                        i_rsp_valid_d = (grant_sel_c == PORT_I);
                        d_rsp_valid_d = (grant_sel_c == PORT_D);
                        i_rsp_err_d   = (grant_sel_c == PORT_I);
                        d_rsp_err_d   = (grant_sel_c == PORT_D);
                    end
                end
            end
            ST_ISSUE: begin
                state_d       = ST_RESP;
                i_rsp_valid_d = (owner_q == PORT_I);
                d_rsp_valid_d = (owner_q == PORT_D);
                i_rsp_err_d   = (owner_q == PORT_I) & err_q;
                d_rsp_err_d   = (owner_q == PORT_D) & err_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= PORT_I;
            last_grant_q  <= PORT_I;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_funct3_q  <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            i_rsp_err_q   <= 1'b0;
            d_rsp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            err_q         <= err_d;
            mem_we_q      <= mem_we_d;
            mem_funct3_q  <= mem_funct3_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            i_rsp_err_q   <= i_rsp_err_d;
            d_rsp_err_q   <= d_rsp_err_d;
        end
    end

    // Memory read data arrives during RESP, so it is steered straight through.
    assign rsp_rd_c    = (state_q == ST_RESP) & ~err_q & ~we_q;
    assign i_rsp_rdata = (rsp_rd_c && owner_q == PORT_I) ? mem_rdata : '0;
    assign d_rsp_rdata = (rsp_rd_c && owner_q == PORT_D) ? mem_rdata : '0;

    assign i_rsp_valid = i_rsp_valid_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign i_rsp_err   = i_rsp_err_q;
    assign d_rsp_err   = d_rsp_err_q;
    assign mem_we      = mem_we_q;
    assign mem_funct3  = mem_funct3_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte memory model and a response scoreboard.
module tb_mem_port_arbiter;

    localparam int unsigned ADDRW = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_req = 1'b0;
    logic [ADDRW-1:0] i_addr = '0;
    logic             i_rsp_valid;
    logic [31:0]      i_rsp_rdata;
    logic             i_rsp_err;
    logic             d_req = 1'b0;
    logic             d_we = 1'b0;
    logic [2:0]       d_funct3 = '0;
    logic [ADDRW-1:0] d_addr = '0;
    logic [31:0]      d_wdata = '0;
    logic             d_rsp_valid;
    logic [31:0]      d_rsp_rdata;
    logic             d_rsp_err;
    logic             mem_we;
    logic [2:0]       mem_funct3;
    logic [ADDRW-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = '0;
    logic             busy;

    mem_port_arbiter #(.ADDRW(ADDRW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               we_cnt = 0;
    logic [ADDRW-1:0] last_waddr = '0;
    logic [2:0]       last_wf3 = '0;
    logic [7:0]       mem [0:(1<<ADDRW)-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [ADDRW-1:0] a, input logic [2:0] f3);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[ADDRW'(a + 1)];
        b2 = mem[ADDRW'(a + 2)];
        b3 = mem[ADDRW'(a + 3)];
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Synchronous memory: write on mem_we, read data one cycle after the address.
    always @(posedge clk) begin
        mem_rdata <= mem_read(mem_addr, mem_funct3);
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[ADDRW'(mem_addr + 1)] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[ADDRW'(mem_addr + 2)] <= mem_wdata[23:16];
                mem[ADDRW'(mem_addr + 3)] <= mem_wdata[31:24];
            end
        end
    end

    // Response monitor: pops the scoreboard on each response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) begin
            we_cnt++;
            last_waddr = mem_addr;
            last_wf3 = mem_funct3;
        end
        if (i_rsp_valid || d_rsp_valid) begin
            check("mon_single_valid", 32'(i_rsp_valid & d_rsp_valid), 32'd0);
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL mon_unexpected observed=i%0d/d%0d expected=none", i_rsp_valid, d_rsp_valid);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mon_port", 32'(d_rsp_valid), 32'(e.is_d));
                check("mon_rdata", e.is_d ? d_rsp_rdata : i_rsp_rdata, e.rdata);
                check("mon_err", 32'(e.is_d ? d_rsp_err : i_rsp_err), 32'(e.err));
                check("mon_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("mon_idle_rsp", i_rsp_rdata | d_rsp_rdata | 32'(i_rsp_err) | 32'(d_rsp_err), 32'd0);
        end
    end

    // One transaction on one port; optional single-cycle request pulse.
    task automatic run_txn(input bit is_d, input logic we, input logic [2:0] f3,
                           input logic [ADDRW-1:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input bit exp_err, input bit pulse,
                           input string tag);
        bit got;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        sb.push_back('{is_d, exp_rdata, exp_err, cyc + (exp_err ? 1 : 2)});
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (pulse && k == 0) begin
                d_req = 1'b0; i_req = 1'b0;
            end
            got = is_d ? d_rsp_valid : i_rsp_valid;
        end
        d_req = 1'b0; i_req = 1'b0;
        check(tag, 32'(got), 32'd1);
    endtask

    initial begin
        int w0;
        int n;
        bit exp_d;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valids", 32'({i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err}), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Preload word via store, then fetch it
        run_txn(1, 1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 0, 0, "sw_preload_done");
        w0 = we_cnt;
        run_txn(0, 0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 0, 0, "fetch_done");
        check("fetch_no_write", 32'(we_cnt - w0), 32'd0);

        // Byte store then loads
        w0 = we_cnt;
        run_txn(1, 1, 3'b000, 12'h023, 32'h000000A5, 32'h0, 0, 0, "sb_done");
        check("sb_we_count", 32'(we_cnt - w0), 32'd1);
        check("sb_we_addr", 32'(last_waddr), 32'h023);
        check("sb_we_funct3", 32'(last_wf3), 32'd0);
        run_txn(1, 0, 3'b100, 12'h023, 32'h0, 32'h000000A5, 0, 0, "lbu_done");
        run_txn(1, 1, 3'b000, 12'h024, 32'h00000080, 32'h0, 0, 0, "sb2_done");
        run_txn(1, 0, 3'b000, 12'h024, 32'h0, 32'hFFFFFF80, 0, 0, "lb_done");
        run_txn(1, 1, 3'b010, 12'h100, 32'h12345678, 32'h0, 0, 0, "sw_done");
        run_txn(1, 0, 3'b001, 12'h102, 32'h0, 32'h00001234, 0, 0, "lh_done");
        run_txn(1, 0, 3'b101, 12'h100, 32'h0, 32'h00005678, 0, 0, "lhu_done");

        // Misaligned and illegal-size accesses
        w0 = we_cnt;
        run_txn(1, 0, 3'b010, 12'h002, 32'h0, 32'h0, 1, 0, "lw_mis_done");
        run_txn(1, 0, 3'b011, 12'h000, 32'h0, 32'h0, 1, 0, "f3_11_done");
        run_txn(1, 1, 3'b001, 12'h001, 32'hFFFF, 32'h0, 1, 0, "sh_mis_done");
        run_txn(0, 0, 3'b010, 12'h012, 32'h0, 32'h0, 1, 0, "fetch_mis_done");
        check("err_no_write", 32'(we_cnt - w0), 32'd0);

        // Reset during ISSUE of a load, with a fetch pending
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 12'h100;
        @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 12'h010;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rsp", 32'({i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err}), 32'd0);
        check("rstmid_rdata", i_rsp_rdata | d_rsp_rdata, 32'd0);
        check("rstmid_mem", 32'({mem_we, mem_funct3, mem_addr}) | mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0, cyc + 2});
        n = 0;
        for (int k = 0; k < 10 && n == 0; k++) begin
            @(negedge clk);
            if (i_rsp_valid) n = 1;
        end
        i_req = 1'b0;
        check("rstmid_fetch_done", 32'(n), 32'd1);

        // Contention: both ports held for six accesses
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 12'h100;
        i_req = 1'b1; i_addr = 12'h010;
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            sb.push_back('{exp_d, exp_d ? 32'h12345678 : 32'hDEADBEEF, 1'b0, cyc + 2 + 3 * k});
        end
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(negedge clk);
            if (i_rsp_valid || d_rsp_valid) n++;
        end
        d_req = 1'b0; i_req = 1'b0;
        check("contend_count", 32'(n), 32'd6);

        // Single-cycle request pulse still completes, once
        run_txn(1, 0, 3'b010, 12'h100, 32'h0, 32'h12345678, 0, 1, "pulse_done");
        repeat (4) @(negedge clk);
        check("pulse_idle", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port byte-addressable data memory between two requesters: instruction fetch (I-port) and load/store (D-port).
- Each transaction is sequenced through issue and response phases.
- Misaligned and illegal-size accesses are rejected with an error response before any memory cycle is issued.
- Sits between the core pipeline and the memory block; drives the memory's we/funct3/addr/wdata and consumes its rdata.

Parameters:
- ADDRW, 12, byte address width of the shared memory (memory size 2^ADDRW bytes).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_rsp_valid.
- i_addr  in  ADDRW  fetch byte address; always a word access.
- i_rsp_valid  out  1  one-cycle pulse; fetch response valid.
- i_rsp_rdata  out  32  fetched word.
- i_rsp_err  out  1  fetch address misaligned; qualified by i_rsp_valid.
- d_req  in  1  load/store request; held with fields stable until d_rsp_valid.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  RV funct3: [2] = unsigned flag, [1:0] = size (00 B, 01 H, 10 W, 11 illegal).
- d_addr  in  ADDRW  byte address.
- d_wdata  in  32  store data, right-aligned.
- d_rsp_valid  out  1  one-cycle pulse; load/store response valid.
- d_rsp_rdata  out  32  load data, already extended by memory; 0 for stores.
- d_rsp_err  out  1  misaligned or illegal size; qualified by d_rsp_valid.
- mem_we  out  1  memory write enable.
- mem_funct3  out  3  memory access type.
- mem_addr  out  ADDRW  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid the cycle after the address is presented.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. While rst_n=0:
  - state = IDLE, owner = I, last_grant = I.
  - All outputs are 0: rsp valids, errs, rdata, mem_* and busy.
  - Reset mid-transaction abandons the transaction with no response and no write; a write already issued in ISSUE stays in memory.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, select a winner and latch it into owner, addr, funct3, we and wdata.
  - The I-port latches funct3=3'b010 and we=0.
  - Alignment check on the latched request:
    - Size H requires addr[0]=0.
    - Size W requires addr[1:0]=0.
    - Size 11 is always illegal.
  - Legal → ISSUE. Illegal → RESP with err pending, no memory cycle.
  - mem_we = 0 in IDLE.
- ISSUE (1 cycle):
  - mem_addr, mem_funct3 and mem_wdata are driven from the latched fields.
  - mem_we = latched we, high for exactly this cycle.
  - → RESP.
- RESP (1 cycle):
  - The owner's rsp_valid = 1.
  - rsp_rdata = mem_rdata for a legal load/fetch, else 0.
  - rsp_err = pending error.
  - mem_we = 0. → IDLE.
- Outside RESP, rsp_valid, rsp_rdata and rsp_err are 0.
- Latency:
  - Legal access: response 2 cycles after the grant cycle, i.e. 3 cycles request-to-response when the arbiter is idle.
  - Erroneous access: response 1 cycle after the grant cycle.
  - Throughput: one access per 3 cycles.
- Arbitration without the optional feature: fixed priority, D beats I. last_grant is still updated.
- A req deasserted mid-transaction does not cancel it; the response still pulses.
- A requester must drop req, or present its next request, in the cycle after rsp_valid. A req high in the IDLE cycle after its own response is a new request.
- mem_addr, mem_funct3 and mem_wdata hold their last values outside ISSUE; only mem_we is qualifying.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both reqs are high in IDLE, grant the port not equal to last_grant; a single requester is always granted. After reset (last_grant=I), the first tie goes to D.
- Undefined: fixed priority, D over I. A continuously requesting D-port may starve the I-port.

Test Plan:
- I-only fetch: i_req=1, i_addr=0x010, memory word 0xDEADBEEF → i_rsp_valid pulses 3rd cycle after request (T+2), i_rsp_rdata=0xDEADBEEF, err=0, mem_we never high.
- D store then load:
  - Store SB (funct3=000) with addr=0x023, wdata=0xA5 → mem_we high exactly 1 cycle with mem_addr=0x023, d_rsp_valid at T+2, rdata=0.
  - Then load LBU (funct3=100) from 0x023 → d_rsp_rdata=0x000000A5.
- Misaligned: d_funct3=010 (LW) with d_addr=0x002 → d_rsp_valid at T+1, d_rsp_err=1, rdata=0, no ISSUE cycle. Same for funct3=011 at addr 0x000.
- Contention with both reqs held for 6 accesses:
  - Without the macro: all 6 grants go to D.
  - With the macro: grants alternate D, I, D, I, D, I.
- Reset mid-op: assert rst_n=0 during ISSUE of a load → all outputs 0 immediately (async), no rsp_valid. After release, a pending i_req completes normally.
- Req drop: d_req pulsed for 1 cycle → transaction completes and d_rsp_valid still pulses; no second access is started.
